mult_div_rs: RTL and testbench

Reservation station that sits directly upstream of the multiply/divide unit. It accepts M-extension instructions from dispatch and captures operand values, or snoops the CDB until they arrive. It selects the oldest entry whose operands are both ready and drives it into the mult/div unit. Operands and enable are held stable until the unit responds.

---
 rtl/mult_div_rs_if.sv | 48 ++++
 rtl/mult_div_rs.sv | 142 ++++++++++++++
 tb/tb_mult_div_rs.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_rs_if.sv
// Handshake bundle between dispatch, CDB, the station and the mult/div unit.
// The slave side is the reservation station itself.
interface mult_div_rs_if #(
   parameter int RS_DEPTH  = 4,
   parameter int ROB_DEPTH = 4
);
   localparam int TW = $clog2(ROB_DEPTH);
   localparam int CW = $clog2(RS_DEPTH + 1);

   logic          dispatch_valid;
   logic          dispatch_ready;
   logic [31:0]   dispatch_instr;
   logic [TW-1:0] dispatch_rob_tag;
   logic          dispatch_rs1_ready;
   logic [31:0]   dispatch_rs1_v;
   logic [TW-1:0] dispatch_rs1_tag;
   logic          dispatch_rs2_ready;
   logic [31:0]   dispatch_rs2_v;
   logic [TW-1:0] dispatch_rs2_tag;
   logic          cdb_valid;
   logic [TW-1:0] cdb_rob;
   logic [31:0]   cdb_value;
   logic          md_en;
   logic [31:0]   md_instr;
   logic [31:0]   md_rs1_v;
   logic [31:0]   md_rs2_v;
   logic [TW-1:0] md_rob_tag;
   logic          md_resp;
   logic [CW-1:0] rs_count;

   modport master (
      output dispatch_valid, dispatch_instr, dispatch_rob_tag,
      output dispatch_rs1_ready, dispatch_rs1_v, dispatch_rs1_tag,
      output dispatch_rs2_ready, dispatch_rs2_v, dispatch_rs2_tag,
      output cdb_valid, cdb_rob, cdb_value, md_resp,
      input  dispatch_ready, md_en, md_instr, md_rs1_v, md_rs2_v,
      input  md_rob_tag, rs_count
   );

   modport slave (
      input  dispatch_valid, dispatch_instr, dispatch_rob_tag,
      input  dispatch_rs1_ready, dispatch_rs1_v, dispatch_rs1_tag,
      input  dispatch_rs2_ready, dispatch_rs2_v, dispatch_rs2_tag,
      input  cdb_valid, cdb_rob, cdb_value, md_resp,
      output dispatch_ready, md_en, md_instr, md_rs1_v, md_rs2_v,
      output md_rob_tag, rs_count
   );
endinterface

// File: rtl/mult_div_rs.sv
// Reservation station for the M-extension unit: collapsing age-ordered
// queue with CDB wakeup, oldest-ready select and held issue registers.
module mult_div_rs #(
   parameter int RS_DEPTH  = 4,
   parameter int ROB_DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   input logic           flush,
   mult_div_rs_if.slave  bus
);
   localparam int TW = $clog2(ROB_DEPTH);
   localparam int CW = $clog2(RS_DEPTH + 1);
   localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   typedef struct packed {
      logic [31:0]   instr;
      logic [TW-1:0] tag;
      logic          r1;
      logic [31:0]   v1;
      logic [TW-1:0] t1;
      logic          r2;
      logic [31:0]   v2;
      logic [TW-1:0] t2;
   } ent_t;

   typedef enum logic {IDLE, BUSY} st_t;

   st_t           st, st_n;
   ent_t          q  [RS_DEPTH];
   ent_t          wk [RS_DEPTH];
   ent_t          nq [RS_DEPTH];
   ent_t          de;
   logic [CW-1:0] cnt, cnt_n, kept;
   logic [IW-1:0] sel;
   logic          has_rdy, issue, accept;
   logic [31:0]   md_instr, md_rs1_v, md_rs2_v;
   logic [TW-1:0] md_rob_tag;

   function automatic ent_t wake(input ent_t e, input logic v,
                                 input logic [TW-1:0] r,
                                 input logic [31:0] d);
      ent_t o;
      o = e;
      if (v && !o.r1 && o.t1 == r) begin
         o.r1 = 1'b1;
         o.v1 = d;
      end
      if (v && !o.r2 && o.t2 == r) begin
         o.r2 = 1'b1;
         o.v2 = d;
      end
      return o;
   endfunction

   always_ff @(posedge clk) begin
      if (rst || flush) st <= IDLE;
      else              st <= st_n;
   end

   always_comb begin
      st_n = st;
      unique case (st)
         IDLE: if (has_rdy) st_n = BUSY;
         BUSY: if (bus.md_resp && !has_rdy) st_n = IDLE;
      endcase
   end

   always_comb begin
      bus.md_en = (st == BUSY);
      issue     = has_rdy && (st == IDLE || bus.md_resp);
   end

   // Scan from the youngest so the oldest ready entry wins.
   always_comb begin
      has_rdy = 1'b0;
      sel     = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (CW'(i) < cnt && q[i].r1 && q[i].r2) begin
            has_rdy = 1'b1;
            sel     = IW'(i);
         end
      end
   end

   assign bus.dispatch_ready = (cnt < CW'(RS_DEPTH));
   assign bus.rs_count       = cnt;

   always_comb begin
      accept = bus.dispatch_valid && bus.dispatch_ready;
      de.instr = bus.dispatch_instr;
      de.tag   = bus.dispatch_rob_tag;
      de.r1    = bus.dispatch_rs1_ready;
      de.v1    = bus.dispatch_rs1_v;
      de.t1    = bus.dispatch_rs1_tag;
      de.r2    = bus.dispatch_rs2_ready;
      de.v2    = bus.dispatch_rs2_v;
      de.t2    = bus.dispatch_rs2_tag;
      de = wake(de, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
      for (int i = 0; i < RS_DEPTH; i++)
         wk[i] = wake(q[i], bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
      for (int i = 0; i < RS_DEPTH; i++) begin
         nq[i] = wk[i];
         if (issue && IW'(i) >= sel) begin
            if (i < RS_DEPTH - 1) nq[i] = wk[i+1];
         end
      end
      kept  = cnt - CW'(issue);
      cnt_n = kept + CW'(accept);
      for (int i = 0; i < RS_DEPTH; i++)
         if (accept && CW'(i) == kept) nq[i] = de;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         cnt <= '0;
         for (int i = 0; i < RS_DEPTH; i++) q[i] <= '0;
      end else begin
         cnt <= cnt_n;
         for (int i = 0; i < RS_DEPTH; i++) q[i] <= nq[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         md_instr   <= '0;
         md_rs1_v   <= '0;
         md_rs2_v   <= '0;
         md_rob_tag <= '0;
      end else if (issue) begin
         md_instr   <= q[sel].instr;
         md_rs1_v   <= q[sel].v1;
         md_rs2_v   <= q[sel].v2;
         md_rob_tag <= q[sel].tag;
      end
   end

   assign bus.md_instr   = md_instr;
   assign bus.md_rs1_v   = md_rs1_v;
   assign bus.md_rs2_v   = md_rs2_v;
   assign bus.md_rob_tag = md_rob_tag;
endmodule

// File: tb/tb_mult_div_rs.sv
// Bench for mult_div_rs: directed scenarios plus random traffic, checked
// against a queue-based station model through an issue scoreboard.
module tb_mult_div_rs;
   localparam int RS_DEPTH = 4;
   localparam int ROB_DEPTH = 4;
   localparam logic [31:0] MUL = 32'h02c58533;
   localparam logic [31:0] DIV = 32'h02c5c533;

   typedef struct {
      logic [31:0] instr;
      logic [1:0]  tag;
      bit          r1;
      logic [31:0] v1;
      logic [1:0]  t1;
      bit          r2;
      logic [31:0] v2;
      logic [1:0]  t2;
   } ent_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [1:0]  tag;
   } iss_t;

   logic clk = 0;
   logic rst = 1;
   logic flush = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_on = 0;
   bit   busy = 0;
   bit   resp_edge = 0;
   bit   prev_en = 0;
   iss_t cur = '0;
   ent_t rs_q[$];
   iss_t exp_q[$];

   mult_div_rs_if #(.RS_DEPTH(RS_DEPTH), .ROB_DEPTH(ROB_DEPTH)) bus();

   mult_div_rs #(.RS_DEPTH(RS_DEPTH), .ROB_DEPTH(ROB_DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [97:0] act, logic [97:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endfunction

   // Reference model: a plain age-ordered list updated once per edge.
   always @(posedge clk) begin
      int   n;
      int   pick;
      bit   acc;
      bit   hit;
      ent_t e;
      resp_edge = bus.md_resp;
      if (rst || flush) begin
         rs_q.delete();
         busy = 0;
         cur = '0;
      end else begin
         n = rs_q.size();
         acc = bus.dispatch_valid && n < RS_DEPTH;
         pick = -1;
         for (int i = 0; i < n; i++)
            if (pick < 0 && rs_q[i].r1 && rs_q[i].r2) pick = i;
         if (!busy || bus.md_resp) begin
            if (pick >= 0) begin
               cur.instr = rs_q[pick].instr;
               cur.v1 = rs_q[pick].v1;
               cur.v2 = rs_q[pick].v2;
               cur.tag = rs_q[pick].tag;
               exp_q.push_back(cur);
               rs_q.delete(pick);
               busy = 1;
            end else begin
               busy = 0;
            end
         end
         if (bus.cdb_valid) begin
            foreach (rs_q[i]) begin
               if (!rs_q[i].r1 && rs_q[i].t1 == bus.cdb_rob) begin
                  rs_q[i].r1 = 1;
                  rs_q[i].v1 = bus.cdb_value;
               end
               if (!rs_q[i].r2 && rs_q[i].t2 == bus.cdb_rob) begin
                  rs_q[i].r2 = 1;
                  rs_q[i].v2 = bus.cdb_value;
               end
            end
         end
         if (acc) begin
            e.instr = bus.dispatch_instr;
            e.tag = bus.dispatch_rob_tag;
            e.t1 = bus.dispatch_rs1_tag;
            e.t2 = bus.dispatch_rs2_tag;
            hit = bus.cdb_valid && bus.cdb_rob == e.t1;
            e.r1 = bus.dispatch_rs1_ready || hit;
            e.v1 = bus.dispatch_rs1_ready ? bus.dispatch_rs1_v
                 : (hit ? bus.cdb_value : bus.dispatch_rs1_v);
            hit = bus.cdb_valid && bus.cdb_rob == e.t2;
            e.r2 = bus.dispatch_rs2_ready || hit;
            e.v2 = bus.dispatch_rs2_ready ? bus.dispatch_rs2_v
                 : (hit ? bus.cdb_value : bus.dispatch_rs2_v);
            rs_q.push_back(e);
         end
      end
   end

   // Monitor: per-cycle state compare plus scoreboard pop on each issue.
   always @(negedge clk) begin
      iss_t got;
      iss_t x;
      if (mon_on) begin
         got = {bus.md_instr, bus.md_rs1_v, bus.md_rs2_v, bus.md_rob_tag};
         chk("md_en", bus.md_en, busy);
         chk("rs_count", bus.rs_count, rs_q.size());
         chk("dispatch_ready", bus.dispatch_ready, rs_q.size() < RS_DEPTH);
         chk("md_regs", got, cur);
         if (bus.md_en && (!prev_en || resp_edge)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL issue got %h want none", got);
            end else begin
               x = exp_q.pop_front();
               chk("issue", got, x);
            end
         end
         prev_en = bus.md_en;
      end
   end

   task automatic nxt();
      @(negedge clk);
      bus.dispatch_valid = 0;
      bus.cdb_valid = 0;
      bus.md_resp = 0;
      flush = 0;
   endtask

   task automatic idle(int n);
      repeat (n) nxt();
   endtask

   task automatic disp(logic [31:0] ins, logic [1:0] tag,
                       bit r1, logic [31:0] v1, logic [1:0] t1,
                       bit r2, logic [31:0] v2, logic [1:0] t2);
      bus.dispatch_valid = 1;
      bus.dispatch_instr = ins;
      bus.dispatch_rob_tag = tag;
      bus.dispatch_rs1_ready = r1;
      bus.dispatch_rs1_v = v1;
      bus.dispatch_rs1_tag = t1;
      bus.dispatch_rs2_ready = r2;
      bus.dispatch_rs2_v = v2;
      bus.dispatch_rs2_tag = t2;
   endtask

   task automatic cdb(logic [1:0] t, logic [31:0] v);
      bus.cdb_valid = 1;
      bus.cdb_rob = t;
      bus.cdb_value = v;
   endtask

   task automatic drain(int n);
      repeat (n) begin
         nxt();
         if (busy) bus.md_resp = 1;
      end
   endtask

   task automatic do_flush();
      nxt();
      flush = 1;
      nxt();
   endtask

   initial begin
      bus.dispatch_valid = 0;
      bus.cdb_valid = 0;
      bus.md_resp = 0;
      disp(0, 0, 0, 0, 0, 0, 0, 0);
      bus.dispatch_valid = 0;
      bus.cdb_rob = 0;
      bus.cdb_value = 0;
      @(posedge clk);
      #1 mon_on = 1;
      nxt();
      chk("reset_md_en", bus.md_en, 0);
      chk("reset_count", bus.rs_count, 0);
      chk("reset_ready", bus.dispatch_ready, 1);
      rst = 0;

      // basic issue
      nxt(); disp(MUL, 2, 1, 7, 0, 1, 6, 0);
      idle(4); bus.md_resp = 1;
      idle(2);

      // CDB wakeup
      nxt(); disp(DIV, 1, 1, 20, 0, 0, 0, 3);
      idle(2); cdb(3, 5);
      idle(3); bus.md_resp = 1;
      idle(2);

      // same-cycle dispatch and broadcast
      nxt(); disp(MUL, 3, 0, 0, 0, 1, 9, 0); cdb(0, 32'hDEADBEEF);
      idle(3); bus.md_resp = 1;
      idle(2);

      // oldest-ready select
      nxt(); disp(MUL, 0, 0, 0, 3, 1, 11, 0);
      nxt(); disp(DIV, 1, 1, 12, 0, 1, 13, 0);
      nxt(); disp(MUL, 2, 1, 14, 0, 1, 15, 0);
      idle(3); bus.md_resp = 1;
      nxt(); cdb(3, 16);
      idle(2); bus.md_resp = 1;
      idle(2); bus.md_resp = 1;
      idle(2);
      do_flush();

      // full station
      nxt(); disp(MUL, 0, 1, 1, 0, 1, 2, 0);
      for (int i = 0; i < 5; i++) begin
         nxt(); disp(DIV, 2'(i), 0, 0, 3, 1, 32'(i), 0);
      end
      nxt();
      chk("full_count", bus.rs_count, 4);
      chk("full_ready", bus.dispatch_ready, 0);
      cdb(3, 77);
      nxt(); bus.md_resp = 1;
      nxt();
      chk("freed_ready", bus.dispatch_ready, 1);
      drain(12);
      do_flush();

      // flush while busy
      nxt(); disp(MUL, 0, 1, 3, 0, 1, 4, 0);
      for (int i = 0; i < 3; i++) begin
         nxt(); disp(DIV, 2'(i + 1), 0, 0, 3, 0, 0, 3);
      end
      nxt();
      chk("pre_flush_en", bus.md_en, 1);
      flush = 1;
      nxt(); bus.md_resp = 1;
      chk("flush_count", bus.rs_count, 0);
      chk("flush_en", bus.md_en, 0);
      idle(3);

      // random traffic
      repeat (3000) begin
         nxt();
         if ($urandom_range(1, 0) == 1)
            disp($urandom(), 2'($urandom()), $urandom_range(1, 0) == 1,
                 $urandom(), 2'($urandom()), $urandom_range(1, 0) == 1,
                 $urandom(), 2'($urandom()));
         if ($urandom_range(9, 0) < 3) cdb(2'($urandom()), $urandom());
         if ($urandom_range(9, 0) < 4) bus.md_resp = 1;
         if ($urandom_range(99, 0) == 0) flush = 1;
      end
      drain(10);
      do_flush();
      idle(2);
      chk("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
